// File: rtl/board_reset_io.sv
// Board reset stretcher, button synchroniser/debouncer with press/release events, and pad OE gating.
// Latency: core reset holds 2^RST_BITS edges after release; buttons settle 2 + 2^DEBOUNCE_BITS edges; pad paths are combinational.
// No backpressure. Optional LONG_PRESS_RESET_EN: holding button 0 for 2^LONG_BITS cycles restarts the reset stretch.
module board_reset_io #(
    parameter int                 RST_BITS      = 16,
    parameter int                 NUM_BTN       = 4,
    parameter int                 DEBOUNCE_BITS = 16,
    parameter int                 NUM_IO        = 8,
    parameter logic [NUM_IO-1:0]  IO_OE_MASK    = '0,
    parameter int                 LONG_BITS     = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  in_btn,
    output logic [NUM_BTN-1:0]  out_btn,
    output logic [NUM_BTN-1:0]  out_btn_press,
    output logic [NUM_BTN-1:0]  out_btn_release,
    output logic                out_core_reset,
    input  logic [NUM_IO-1:0]   in_core_io_o,
    input  logic [NUM_IO-1:0]   in_core_io_oe,
    output logic [NUM_IO-1:0]   out_pad_o,
    output logic [NUM_IO-1:0]   out_pad_oe,
    input  logic [NUM_IO-1:0]   in_pad_i,
    output logic [NUM_IO-1:0]   out_core_io_i
);

    localparam logic [RST_BITS-1:0]      RST_ONE = {{(RST_BITS-1){1'b0}}, 1'b1};
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE  = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

    logic [RST_BITS-1:0]      cnt;
    logic                     done;
    logic                     long_trig;

    logic [NUM_BTN-1:0]       sync1;
    logic [NUM_BTN-1:0]       sync2;
    logic [NUM_BTN-1:0]       lvl;
    logic [NUM_BTN-1:0]       press_r;
    logic [NUM_BTN-1:0]       release_r;
    logic [DEBOUNCE_BITS-1:0] dc [NUM_BTN];

    // Reset stretcher: done rises on the increment out of all-ones.
    always_ff @(posedge clock) begin
        if (reset || long_trig) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            cnt <= cnt + RST_ONE;
            if (&cnt) begin
                done <= 1'b1;
            end
        end
    end

    assign out_core_reset = ~done;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            lvl       <= '0;
            press_r   <= '0;
            release_r <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                dc[i] <= '0;
            end
        end else begin
            sync1 <= in_btn;
            sync2 <= sync1;
            for (int i = 0; i < NUM_BTN; i++) begin
                press_r[i]   <= 1'b0;
                release_r[i] <= 1'b0;
                if (sync2[i] == lvl[i]) begin
                    dc[i] <= '0;
                end else if (&dc[i]) begin
                    lvl[i]       <= sync2[i];
                    dc[i]        <= '0;
                    press_r[i]   <= sync2[i];
                    release_r[i] <= ~sync2[i];
                end else begin
                    dc[i] <= dc[i] + DB_ONE;
                end
            end
        end
    end

    // Levels keep tracking during the stretch; only the events are hidden from the core.
    assign out_btn         = lvl;
    assign out_btn_press   = press_r   & {NUM_BTN{done}};
    assign out_btn_release = release_r & {NUM_BTN{done}};

`ifdef LONG_PRESS_RESET_EN
    localparam logic [LONG_BITS-1:0] LP_ONE = {{(LONG_BITS-1){1'b0}}, 1'b1};

    logic [LONG_BITS-1:0] lp_cnt;
    logic                 lp_sat;

    // lp_sat latches after the single retrigger so a continued hold does not fire again.
    assign long_trig = lvl[0] & ~lp_sat & (&lp_cnt);

    always_ff @(posedge clock) begin
        if (reset || !lvl[0]) begin
            lp_cnt <= '0;
            lp_sat <= 1'b0;
        end else if (!lp_sat) begin
            if (&lp_cnt) begin
                lp_sat <= 1'b1;
            end else begin
                lp_cnt <= lp_cnt + LP_ONE;
            end
        end
    end
`else
    // Button 0 is an ordinary button in this build.
    assign long_trig = (LONG_BITS < 0);
`endif

    assign out_pad_o     = in_core_io_o;
    assign out_pad_oe    = {NUM_IO{done}} & (in_core_io_oe | IO_OE_MASK);
    assign out_core_io_i = in_pad_i;

endmodule

// File: tb/tb_board_reset_io.sv
// Directed bench for board_reset_io: stretch timing, pad OE gating, debounce, events, long press.
module tb_board_reset_io;

    logic       clock;
    logic       reset;
    logic [3:0] in_btn;
    logic [3:0] out_btn;
    logic [3:0] out_btn_press;
    logic [3:0] out_btn_release;
    logic       out_core_reset;
    logic [7:0] in_core_io_o;
    logic [7:0] in_core_io_oe;
    logic [7:0] out_pad_o;
    logic [7:0] out_pad_oe;
    logic [7:0] in_pad_i;
    logic [7:0] out_core_io_i;

    int passes = 0;
    int total  = 0;

    board_reset_io #(
        .RST_BITS      (4),
        .NUM_BTN       (4),
        .DEBOUNCE_BITS (2),
        .NUM_IO        (8),
        .IO_OE_MASK    (8'b1100_1001),
        .LONG_BITS     (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_btn          (in_btn),
        .out_btn         (out_btn),
        .out_btn_press   (out_btn_press),
        .out_btn_release (out_btn_release),
        .out_core_reset  (out_core_reset),
        .in_core_io_o    (in_core_io_o),
        .in_core_io_oe   (in_core_io_oe),
        .out_pad_o       (out_pad_o),
        .out_pad_oe      (out_pad_oe),
        .in_pad_i        (in_pad_i),
        .out_core_io_i   (out_core_io_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 2 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        reset         = 1'b1;
        in_btn        = 4'b0000;
        in_core_io_o  = 8'hA5;
        in_core_io_oe = 8'h00;
        in_pad_i      = 8'h3C;

        // Edge 0 is the last edge that samples reset=1.
        step(3);
        chk("rst_core_reset", 32'(out_core_reset), 32'd1);
        chk("rst_btn", 32'(out_btn), 32'h0);
        chk("rst_press", 32'(out_btn_press), 32'h0);
        chk("rst_release", 32'(out_btn_release), 32'h0);
        chk("rst_pad_oe", 32'(out_pad_oe), 32'h00);
        chk("pad_o_pass", 32'(out_pad_o), 32'hA5);
        chk("core_io_i_pass", 32'(out_core_io_i), 32'h3C);

        // Release reset and press button 3 during the stretch.
        reset  = 1'b0;
        in_btn = 4'b1000;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            chk("stretch_core_reset", 32'(out_core_reset), 32'd1);
            chk("stretch_pad_oe", 32'(out_pad_oe), 32'h00);
            if (k == 5) chk("stretch_btn3_before", 32'(out_btn), 32'h0);
            if (k == 6) begin
                chk("stretch_btn3_level", 32'(out_btn), 32'h8);
                chk("stretch_btn3_press_masked", 32'(out_btn_press), 32'h0);
            end
        end
        step(1);
        chk("stretch_end_core_reset", 32'(out_core_reset), 32'd0);
        chk("stretch_end_pad_oe_mask", 32'(out_pad_oe), 32'hC9);

        // Release button 3 after the stretch: release event is visible.
        in_btn = 4'b0000;
        step(5);
        chk("btn3_rel_before", 32'(out_btn), 32'h8);
        step(1);
        chk("btn3_rel_level", 32'(out_btn), 32'h0);
        chk("btn3_rel_pulse", 32'(out_btn_release), 32'h8);
        step(1);
        chk("btn3_rel_pulse_end", 32'(out_btn_release), 32'h0);

        // Core OEs combine with the mask.
        in_core_io_oe = 8'h36;
        #1;
        chk("pad_oe_core_or_mask", 32'(out_pad_oe), 32'hFF);

        // One-cycle reset pulse restarts the stretch.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_pulse_core_reset", 32'(out_core_reset), 32'd1);
        chk("rst_pulse_pad_oe", 32'(out_pad_oe), 32'h00);
        step(15);
        chk("rst_pulse_pad_oe_15", 32'(out_pad_oe), 32'h00);
        chk("rst_pulse_core_reset_15", 32'(out_core_reset), 32'd1);
        step(1);
        chk("rst_pulse_pad_oe_16", 32'(out_pad_oe), 32'hFF);
        chk("rst_pulse_core_reset_16", 32'(out_core_reset), 32'd0);
        in_core_io_oe = 8'h00;
        #1;
        chk("pad_oe_mask_only", 32'(out_pad_oe), 32'hC9);

        // Button 1 press and hold.
        in_btn = 4'b0010;
        step(5);
        chk("btn1_before", 32'(out_btn), 32'h0);
        chk("btn1_press_before", 32'(out_btn_press), 32'h0);
        step(1);
        chk("btn1_level", 32'(out_btn), 32'h2);
        chk("btn1_press", 32'(out_btn_press), 32'h2);
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("btn1_hold_no_repeat", 32'(out_btn_press), 32'h0);
        end
        chk("btn1_hold_level", 32'(out_btn), 32'h2);

        // Button 1 release.
        in_btn = 4'b0000;
        step(6);
        chk("btn1_release_level", 32'(out_btn), 32'h0);
        chk("btn1_release", 32'(out_btn_release), 32'h2);
        step(1);
        chk("btn1_release_end", 32'(out_btn_release), 32'h0);

        // Button 2 glitch shorter than the debounce window.
        in_btn = 4'b0100;
        step(3);
        in_btn = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("btn2_glitch_level", 32'(out_btn), 32'h0);
            chk("btn2_glitch_press", 32'(out_btn_press), 32'h0);
        end

        // Hold button 0.
        in_btn = 4'b0001;
        step(6);
        chk("btn0_level", 32'(out_btn), 32'h1);
        chk("btn0_press", 32'(out_btn_press), 32'h1);
`ifdef LONG_PRESS_RESET_EN
        step(31);
        chk("long_before", 32'(out_core_reset), 32'd0);
        step(1);
        chk("long_trigger", 32'(out_core_reset), 32'd1);
        chk("long_trigger_pad_oe", 32'(out_pad_oe), 32'h00);
        step(15);
        chk("long_stretch_15", 32'(out_core_reset), 32'd1);
        step(1);
        chk("long_stretch_end", 32'(out_core_reset), 32'd0);
        for (int k = 0; k < 60; k++) begin
            step(1);
            chk("long_no_retrigger", 32'(out_core_reset), 32'd0);
        end
`else
        for (int k = 0; k < 80; k++) begin
            step(1);
            chk("no_long_press", 32'(out_core_reset), 32'd0);
        end
`endif
        chk("btn0_hold_level", 32'(out_btn), 32'h1);

        in_btn = 4'b0000;
        step(6);
        chk("btn0_release", 32'(out_btn_release), 32'h1);
        chk("btn0_release_level", 32'(out_btn), 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
